// File: rtl/wb_uart_tx_pkg.sv
// Register map, STATUS layout and transmitter state encoding shared by the
// Wishbone UART transmitter and its testbench.
package wb_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  localparam logic [7:0] OFF_DATA   = 8'h00;
  localparam logic [7:0] OFF_DIV    = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;

  localparam int STAT_LVL_W = 5;
  localparam int STAT_EMPTY = 5;
  localparam int STAT_FULL  = 6;
  localparam int STAT_BUSY  = 7;
  localparam int STAT_OVF   = 8;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [7:0] off;
  } wb_req_t;

  function automatic logic [31:0] status_word(
    input logic [STAT_LVL_W-1:0] lvl,
    input logic                  empty,
    input logic                  full,
    input logic                  busy,
    input logic                  ovf
  );
    logic [31:0] w;
    w                   = '0;
    w[STAT_LVL_W-1:0]   = lvl;
    w[STAT_EMPTY]       = empty;
    w[STAT_FULL]        = full;
    w[STAT_BUSY]        = busy;
    w[STAT_OVF]         = ovf;
    return w;
  endfunction

endpackage

// File: rtl/wb_uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop frees a slot for a push on
// the same edge, so a full FIFO still accepts a byte while being drained.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop & (level_q != '0);
    do_push  = push & ((level_q != LW'(DEPTH)) | do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-mapped 8N1 UART transmitter: DATA/DIV/STATUS registers, a byte
// FIFO and a baud-timed shift FSM driving the tx pin.
module wb_uart_tx
  import wb_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0500,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        tx,
  output logic        busy
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  wb_req_t       req;
  logic          mapped, take;
  logic          push, pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [LW-1:0] fifo_level;

  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic [15:0]   div_q, div_d;
  logic          ovf_q, ovf_d;

  tx_state_e     state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   lat_q, lat_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          bit_end;

  logic          unused_dat;
  assign unused_dat = ^wbs_dat_i[31:16];

  // Decode; an access is taken only while ack is low, giving one-cycle acks.
  always_comb begin
    req.rd  = wbs_cyc_i & wbs_stb_i & ~wbs_we_i;
    req.wr  = wbs_cyc_i & wbs_stb_i & wbs_we_i & (wbs_sel_i != 4'h0);
    req.off = wbs_adr_i[7:0];
    mapped  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]) &
              ((req.off == OFF_DATA) | (req.off == OFF_DIV) | (req.off == OFF_STATUS));
    take    = wbs_cyc_i & wbs_stb_i & mapped & ~ack_q;
    push    = take & req.wr & (req.off == OFF_DATA) & wbs_sel_i[0];
  end

  always_comb begin
    ack_d = take;
    dat_d = '0;
    div_d = div_q;
    ovf_d = ovf_q;
    if (take && req.rd) begin
      case (req.off)
        OFF_DIV:    dat_d = {16'h0, div_q};
        OFF_STATUS: begin
          dat_d = status_word(STAT_LVL_W'(fifo_level), fifo_empty, fifo_full, busy_q, ovf_q);
          ovf_d = 1'b0;
        end
        default:    dat_d = '0;
      endcase
    end
    if (take && req.wr && (req.off == OFF_DIV) && (wbs_sel_i == 4'hF) &&
        (wbs_dat_i[15:0] > 16'd1))
      div_d = wbs_dat_i[15:0];
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      div_q <= DEFAULT_DIV;
      ovf_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      div_q <= div_d;
      ovf_q <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (wbs_dat_i[7:0]),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // The divider is latched per frame so DIV writes never stretch a live frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    bit_end = (cnt_q == lat_q - 16'd1);
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          lat_d   = div_q;
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            lat_d   = div_q;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lat_q   <= DEFAULT_DIV;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign tx        = tx_q;
  assign busy      = busy_q;

endmodule
